pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/fetch_pkg.sv | 38 +++
 rtl/branch_lut.sv | 15 +
 rtl/pc_fetch.sv | 113 +++++++++++
 tb/tb_pc_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch block: opcodes, FSM states, halt word
// and the branch target table.
package fetch_pkg;

   typedef enum logic [2:0] {
      OpAdd   = 3'b000,
      OpAnd   = 3'b001,
      OpXor   = 3'b010,
      OpBeq   = 3'b011,
      OpMov   = 3'b100,
      OpLoad  = 3'b101,
      OpStore = 3'b110,
      OpRtl   = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam logic [8:0] HALT_INSTR = 9'h1FF;

   localparam int unsigned LUT_W = 16;

   // Entry i holds 2*(i+1); consumers keep the low PC_W bits.
   localparam logic [LUT_W-1:0] BRANCH_LUT [64] = '{
      16'd2,   16'd4,   16'd6,   16'd8,   16'd10,  16'd12,  16'd14,  16'd16,
      16'd18,  16'd20,  16'd22,  16'd24,  16'd26,  16'd28,  16'd30,  16'd32,
      16'd34,  16'd36,  16'd38,  16'd40,  16'd42,  16'd44,  16'd46,  16'd48,
      16'd50,  16'd52,  16'd54,  16'd56,  16'd58,  16'd60,  16'd62,  16'd64,
      16'd66,  16'd68,  16'd70,  16'd72,  16'd74,  16'd76,  16'd78,  16'd80,
      16'd82,  16'd84,  16'd86,  16'd88,  16'd90,  16'd92,  16'd94,  16'd96,
      16'd98,  16'd100, 16'd102, 16'd104, 16'd106, 16'd108, 16'd110, 16'd112,
      16'd114, 16'd116, 16'd118, 16'd120, 16'd122, 16'd124, 16'd126, 16'd128
   };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch target lookup: {rs,rt} index to a PC_W-bit target.
module branch_lut
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W = 10
) (
   input  logic [5:0]      idx_i,
   output logic [PC_W-1:0] target_o
);

   always_comb begin
      target_o = BRANCH_LUT[idx_i][PC_W-1:0];
   end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE, one instruction per cycle.
// Optional PC_FETCH_CYCLE_COUNT_EN adds a saturating 16-bit valid-instruction counter.
module pc_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned    PC_W     = 10,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [8:0]      instr_in,
   input  logic            zero,
   output logic [PC_W-1:0] instr_addr,
   output logic [2:0]      alu_cmd,
   output logic [2:0]      rd_addrA,
   output logic [2:0]      rd_addrB,
   output logic            valid,
`ifdef PC_FETCH_CYCLE_COUNT_EN
   output logic [15:0]     instr_count,
`endif
   output logic            reg_wr_en,
   output logic            done
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] br_target;
   opcode_e         op;
   logic            start_acc;

   assign op = opcode_e'(instr_in[8:6]);

   branch_lut #(
      .PC_W (PC_W)
   ) u_branch_lut (
      .idx_i    (instr_in[5:0]),
      .target_o (br_target)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid     = 1'b0;
      start_acc = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StRun;
               pc_d      = START_PC;
               start_acc = 1'b1;
            end
         end
         StRun: begin
            if (instr_in == HALT_INSTR) begin
               state_d = StDone;
            end else begin
               valid = 1'b1;
               if (op == OpBeq && zero) begin
                  pc_d = br_target;
               end else if (pc_q == '1) begin
                  // Falling off the top of the address space ends the program.
                  state_d = StDone;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= START_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifdef PC_FETCH_CYCLE_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_acc) begin
         cnt_d = '0;
      end else if (valid && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign instr_count = cnt_q;
`endif

   assign instr_addr = pc_q;
   assign alu_cmd    = instr_in[8:6];
   assign rd_addrA   = instr_in[5:3];
   assign rd_addrB   = instr_in[2:0];
   assign reg_wr_en  = valid && (op != OpBeq) && (op != OpStore);
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch (PC_W=10 and PC_W=4 instances).
// Counter checks are included when PC_FETCH_CYCLE_COUNT_EN is defined.
module tb_pc_fetch;

   localparam logic [8:0] ADD_I   = 9'b000_001_010;
   localparam logic [8:0] STORE_I = 9'b110_000_000;
   localparam logic [8:0] BEQ_I   = 9'b011_010_011;
   localparam logic [8:0] BEQ0_I  = 9'b011_000_000;
   localparam logic [8:0] HALT_I  = 9'h1FF;

   logic       clk;
   logic       reset, start, zero;
   logic [8:0] instr;
   logic [9:0] instr_addr;
   logic [2:0] alu_cmd, rd_a, rd_b;
   logic       valid, wr_en, done;

   logic       reset4, start4, zero4;
   logic [8:0] instr4;
   logic [3:0] instr_addr4;
   logic [2:0] alu_cmd4, rd_a4, rd_b4;
   logic       valid4, wr_en4, done4;

`ifdef PC_FETCH_CYCLE_COUNT_EN
   logic [15:0] count, count4;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pc_fetch #(
      .PC_W     (10),
      .START_PC (10'd0)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instr_in    (instr),
      .zero        (zero),
      .instr_addr  (instr_addr),
      .alu_cmd     (alu_cmd),
      .rd_addrA    (rd_a),
      .rd_addrB    (rd_b),
      .valid       (valid),
`ifdef PC_FETCH_CYCLE_COUNT_EN
      .instr_count (count),
`endif
      .reg_wr_en   (wr_en),
      .done        (done)
   );

   pc_fetch #(
      .PC_W     (4),
      .START_PC (4'd0)
   ) u_dut4 (
      .clk         (clk),
      .reset       (reset4),
      .start       (start4),
      .instr_in    (instr4),
      .zero        (zero4),
      .instr_addr  (instr_addr4),
      .alu_cmd     (alu_cmd4),
      .rd_addrA    (rd_a4),
      .rd_addrB    (rd_b4),
      .valid       (valid4),
`ifdef PC_FETCH_CYCLE_COUNT_EN
      .instr_count (count4),
`endif
      .reg_wr_en   (wr_en4),
      .done        (done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the edge; checks follow 1 unit later.
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; instr = ADD_I; zero = 1'b0;
      reset4 = 1'b1; start4 = 1'b0; instr4 = ADD_I; zero4 = 1'b0;
      tick; tick;
      reset = 1'b0;
      #1;
      check_eq("rst_addr", 32'(instr_addr), 0);
      check_eq("rst_valid", 32'(valid), 0);
      check_eq("rst_wr_en", 32'(wr_en), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("idle_alu_cmd", 32'(alu_cmd), 0);
      check_eq("idle_rd_a", 32'(rd_a), 1);
      check_eq("idle_rd_b", 32'(rd_b), 2);

      start = 1'b1; tick; start = 1'b0; #1;
      check_eq("run_addr0", 32'(instr_addr), 0);
      check_eq("run_valid", 32'(valid), 1);
      check_eq("run_wr_en_add", 32'(wr_en), 1);
      for (int i = 1; i <= 3; i++) begin
         tick; #1;
         check_eq("seq_addr", 32'(instr_addr), 32'(i));
      end
      instr = STORE_I; #1;
      check_eq("store_valid", 32'(valid), 1);
      check_eq("store_wr_en", 32'(wr_en), 0);
      tick; instr = BEQ_I; zero = 1'b0; #1;
      check_eq("beq_nt_addr", 32'(instr_addr), 4);
      check_eq("beq_wr_en", 32'(wr_en), 0);
      tick; instr = HALT_I; #1;
      check_eq("beq_nt_next", 32'(instr_addr), 5);
      check_eq("halt_valid", 32'(valid), 0);
      tick; instr = ADD_I; #1;
      check_eq("halt_done", 32'(done), 1);
      check_eq("halt_addr", 32'(instr_addr), 5);
      check_eq("done_valid", 32'(valid), 0);

      start = 1'b1; tick; start = 1'b0; #1;
      check_eq("restart_addr", 32'(instr_addr), 0);
      check_eq("restart_done", 32'(done), 0);
      instr = BEQ_I; zero = 1'b1; #1;
      check_eq("beq_t_valid", 32'(valid), 1);
      check_eq("beq_t_wr_en", 32'(wr_en), 0);
      tick; #1;
      check_eq("beq_t_addr", 32'(instr_addr), 40);
      tick; #1;
      check_eq("beq_self_loop", 32'(instr_addr), 40);
      zero = 1'b0; tick; #1;
      check_eq("beq_loop_exit", 32'(instr_addr), 41);
      instr = ADD_I; start = 1'b1; tick; start = 1'b0; #1;
      check_eq("start_ign_run", 32'(instr_addr), 42);

      instr = HALT_I; tick;
      instr = ADD_I; start = 1'b1; tick; start = 1'b0;
      for (int i = 0; i < 7; i++) tick;
      #1;
      check_eq("mid_run_addr", 32'(instr_addr), 7);
      reset = 1'b1; start = 1'b1; tick; reset = 1'b0; start = 1'b0; #1;
      check_eq("rst_run_addr", 32'(instr_addr), 0);
      check_eq("rst_run_valid", 32'(valid), 0);
      check_eq("rst_run_done", 32'(done), 0);
      tick; #1;
      check_eq("rst_idle_addr", 32'(instr_addr), 0);
      check_eq("rst_idle_valid", 32'(valid), 0);

      start = 1'b1; tick; start = 1'b0; #1;
`ifdef PC_FETCH_CYCLE_COUNT_EN
      check_eq("cnt_clear", 32'(count), 0);
`endif
      for (int i = 0; i < 6; i++) tick;
      instr = HALT_I; #1;
      check_eq("cnt_run_addr", 32'(instr_addr), 6);
      tick; instr = ADD_I; #1;
      check_eq("cnt_done", 32'(done), 1);
`ifdef PC_FETCH_CYCLE_COUNT_EN
      check_eq("cnt_six", 32'(count), 6);
      tick; #1;
      check_eq("cnt_hold", 32'(count), 6);
`endif

      // Top-of-address-space behaviour on the 4-bit PC instance.
      reset4 = 1'b0; start4 = 1'b1; tick; start4 = 1'b0; #1;
      check_eq("w4_addr0", 32'(instr_addr4), 0);
      for (int i = 1; i <= 15; i++) begin
         tick; #1;
         check_eq("w4_seq_addr", 32'(instr_addr4), 32'(i));
      end
      check_eq("w4_top_valid", 32'(valid4), 1);
      tick; #1;
      check_eq("w4_top_done", 32'(done4), 1);
      check_eq("w4_no_wrap", 32'(instr_addr4), 15);
      check_eq("w4_done_valid", 32'(valid4), 0);
      start4 = 1'b1; tick; start4 = 1'b0;
      for (int i = 0; i < 15; i++) tick;
      instr4 = BEQ0_I; zero4 = 1'b1; #1;
      check_eq("w4_top_again", 32'(instr_addr4), 15);
      tick; #1;
      check_eq("w4_top_branch", 32'(instr_addr4), 2);
      check_eq("w4_branch_run", 32'(done4), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
